// File: rtl/pos_cell_access_ctrl_pkg.sv
// Shared definitions for the cell position RAM access controller:
// default parameter values, the read-sequencer state encoding and a
// small helper for sizing the latency counter.
package pos_cell_access_ctrl_pkg;

  localparam int DATA_WIDTH_DEF   = 96;
  localparam int PARTICLE_NUM_DEF = 220;
  localparam int ADDR_WIDTH_DEF   = 8;
  localparam int MEM_LAT_DEF      = 2;

  // Read sequencer states. IDLE is the only state in which the write
  // requester can be granted the RAM port.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,  // port free, writes may be granted
    ST_CNT      = 3'd1,  // count read (addr 0) is on the RAM port
    ST_CNT_WAIT = 3'd2,  // waiting for the count to come back
    ST_STREAM   = 3'd3,  // issuing addr 1..N, one per cycle
    ST_DRAIN    = 3'd4   // waiting for the last reads to return
  } rd_state_e;

  // Width of a counter that has to reach lat-1; never narrower than 1.
  function automatic int lat_cnt_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/pos_cell_access_ctrl_rd_tag_pipe.sv
// Tag shift register that travels alongside RAM reads. Each stage holds
// {valid, pid, last} for one outstanding read, so that the tag leaves the
// pipe in the same cycle the RAM presents the matching data word.
module pos_cell_access_ctrl_rd_tag_pipe #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [ADDR_WIDTH-1:0] in_pid,
  input  logic                  in_last,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_pid,
  output logic                  out_last
);

  logic [DEPTH-1:0]      valid_q;
  logic [DEPTH-1:0]      valid_d;
  logic [DEPTH-1:0]      last_q;
  logic [DEPTH-1:0]      last_d;
  logic [ADDR_WIDTH-1:0] pid_q [DEPTH];
  logic [ADDR_WIDTH-1:0] pid_d [DEPTH];

  // Shift every stage one step towards the output each cycle.
  always_comb begin
    valid_d[0] = in_valid;
    last_d[0]  = in_last;
    pid_d[0]   = in_pid;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      last_d[i]  = last_q[i-1];
      pid_d[i]   = pid_q[i-1];
    end
  end

  // Stage registers; reset discards every tag still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      last_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pid_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
      for (int i = 0; i < DEPTH; i++) begin
        pid_q[i] <= pid_d[i];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_pid   = pid_q[DEPTH-1];
  assign out_last  = last_q[DEPTH-1];

endmodule

// File: rtl/pos_cell_access_ctrl.sv
// Sequencer/arbiter for one single-port cell position RAM.
//
// Two requesters share the RAM port:
//   - the force-evaluation reader pulses rd_start to stream the whole
//     cell: the count is read from addr 0, clamped to PARTICLE_NUM-1, and
//     addr 1..N are then read back-to-back. Every returned word is tagged
//     with its particle id and a last flag; rd_done pulses on the cycle of
//     the final word (or shortly after the count read when the cell is
//     empty).
//   - the motion-update writer holds wr_req (with wr_addr/wr_data stable)
//     until it sees wr_grant. Handshake: a write is transferred in exactly
//     the cycle where wr_req=1 and wr_grant=1; the requester may change
//     address/data or drop wr_req from the next cycle on. Grants are only
//     given while the sequencer is idle and no read is being started, so a
//     read start always wins and writes stall for the whole stream.
//
// All RAM-side outputs are registered. rd_data is the RAM q passed
// straight through; the tag pipe lines the tags up with it.
// The sequencer state is kept in state_q (type rd_state_e) so that it can
// be probed directly.
module pos_cell_access_ctrl
  import pos_cell_access_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int PARTICLE_NUM = PARTICLE_NUM_DEF,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int MEM_LAT      = MEM_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  // stream reader
  input  logic                  rd_start,
  output logic                  rd_busy,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] rd_pid,
  output logic                  rd_last,
  output logic                  rd_done,
  output logic [ADDR_WIDTH-1:0] rd_count,
  // single-word writer
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_grant,
  // RAM port
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  localparam int WCW = lat_cnt_width(MEM_LAT);
  localparam logic [WCW-1:0]        LAT_LAST = WCW'(MEM_LAT - 1);
  localparam logic [ADDR_WIDTH-1:0] MAX_N    = ADDR_WIDTH'(PARTICLE_NUM - 1);

  // Sequencer state
  rd_state_e             state_q;
  rd_state_e             state_d;
  logic [WCW-1:0]        wait_q;
  logic [WCW-1:0]        wait_d;
  logic [ADDR_WIDTH-1:0] n_q;
  logic [ADDR_WIDTH-1:0] n_d;

  // Registered RAM port
  logic [ADDR_WIDTH-1:0] mem_address_q;
  logic [ADDR_WIDTH-1:0] mem_address_d;
  logic                  mem_rden_q;
  logic                  mem_rden_d;
  logic                  mem_wren_q;
  logic                  mem_wren_d;
  logic [DATA_WIDTH-1:0] mem_data_q;
  logic [DATA_WIDTH-1:0] mem_data_d;

  // Helpers
  logic [ADDR_WIDTH-1:0] n_raw;
  logic [ADDR_WIDTH-1:0] n_cap;
  logic                  wait_last;
  logic                  issue_last;
  logic                  tag_in_valid;
  logic                  tag_in_last;

  // The count word only contributes its low ADDR_WIDTH bits; anything
  // above the RAM depth would address past the cell, so it is clamped.
  assign n_raw      = mem_q[ADDR_WIDTH-1:0];
  assign n_cap      = (n_raw > MAX_N) ? MAX_N : n_raw;
  assign wait_last  = (wait_q == LAT_LAST);
  // In STREAM, mem_address_q is the address currently on the RAM port.
  assign issue_last = (mem_address_q == n_q);

  assign wr_grant   = wr_req & (state_q == ST_IDLE) & ~rd_start;

  // FSM state register plus latency counter and captured count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      n_q     <= n_d;
    end
  end

  // Next-state logic: count read, latency wait, stream, drain.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    n_d     = n_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rd_start) begin
          state_d = ST_CNT;
        end
      end
      ST_CNT: begin
        state_d = ST_CNT_WAIT;
        wait_d  = '0;
      end
      ST_CNT_WAIT: begin
        if (wait_last) begin
          // The count is on mem_q this cycle.
          n_d = n_cap;
          if (n_cap == '0) begin
            // Empty cell: skip straight to the final drain cycle so that
            // rd_done follows the count read by one cycle.
            state_d = ST_DRAIN;
            wait_d  = LAT_LAST;
          end else begin
            state_d = ST_STREAM;
          end
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      ST_STREAM: begin
        if (issue_last) begin
          state_d = ST_DRAIN;
          wait_d  = '0;
        end
      end
      ST_DRAIN: begin
        if (wait_last) begin
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: what goes onto the RAM port next cycle, write mux.
  always_comb begin
    mem_rden_d    = 1'b0;
    mem_wren_d    = 1'b0;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rd_start) begin
          mem_rden_d    = 1'b1;
          mem_address_d = '0;
        end else if (wr_grant) begin
          mem_wren_d    = 1'b1;
          mem_address_d = wr_addr;
          mem_data_d    = wr_data;
        end
      end
      ST_CNT_WAIT: begin
        if (wait_last && (n_cap != '0)) begin
          mem_rden_d    = 1'b1;
          mem_address_d = ADDR_WIDTH'(1);
        end
      end
      ST_STREAM: begin
        if (!issue_last) begin
          mem_rden_d    = 1'b1;
          mem_address_d = mem_address_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // Registered RAM port; cleared on reset so no access leaks out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_address_q <= '0;
      mem_rden_q    <= 1'b0;
      mem_wren_q    <= 1'b0;
      mem_data_q    <= '0;
    end else begin
      mem_address_q <= mem_address_d;
      mem_rden_q    <= mem_rden_d;
      mem_wren_q    <= mem_wren_d;
      mem_data_q    <= mem_data_d;
    end
  end

  // A stream read is on the port in every STREAM cycle; the count read
  // in CNT is deliberately not tagged.
  assign tag_in_valid = (state_q == ST_STREAM);
  assign tag_in_last  = tag_in_valid & issue_last;

  pos_cell_access_ctrl_rd_tag_pipe #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (MEM_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (tag_in_valid),
    .in_pid    (mem_address_q),
    .in_last   (tag_in_last),
    .out_valid (rd_valid),
    .out_pid   (rd_pid),
    .out_last  (rd_last)
  );

  assign rd_data     = mem_q;
  assign rd_busy     = (state_q != ST_IDLE);
  assign rd_done     = (state_q == ST_DRAIN) && wait_last;
  assign rd_count    = n_q;

  assign mem_address = mem_address_q;
  assign mem_rden    = mem_rden_q;
  assign mem_wren    = mem_wren_q;
  assign mem_data    = mem_data_q;

endmodule

// File: tb/tb_pos_cell_access_ctrl.sv
// Bench for pos_cell_access_ctrl: a 2-cycle-latency RAM model, driver
// tasks for the reader and writer, a reference model that predicts every
// streamed word from a shadow copy of the RAM, and a monitor that pops
// the expected queues whenever the DUT presents data or rd_done.
module tb_pos_cell_access_ctrl;

  localparam int DW  = 96;
  localparam int AW  = 8;
  localparam int PN  = 220;
  localparam int LAT = 2;
  localparam int EW  = 32 + DW + AW + 1;  // {cycle, data, pid, last}
  localparam int DNW = 32 + AW;           // {cycle, count}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic          rd_start;
  logic          rd_busy;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] rd_pid;
  logic          rd_last;
  logic          rd_done;
  logic [AW-1:0] rd_count;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_grant;
  logic [AW-1:0] mem_address;
  logic          mem_rden;
  logic          mem_wren;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_q;

  pos_cell_access_ctrl #(
    .DATA_WIDTH   (DW),
    .PARTICLE_NUM (PN),
    .ADDR_WIDTH   (AW),
    .MEM_LAT      (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_start    (rd_start),
    .rd_busy     (rd_busy),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_pid      (rd_pid),
    .rd_last     (rd_last),
    .rd_done     (rd_done),
    .rd_count    (rd_count),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_grant    (wr_grant),
    .mem_address (mem_address),
    .mem_rden    (mem_rden),
    .mem_wren    (mem_wren),
    .mem_data    (mem_data),
    .mem_q       (mem_q)
  );

  // ---------------- RAM model (2-cycle read latency) ----------------
  logic [DW-1:0] ram [256];
  logic [DW-1:0] ram_r1;
  always @(posedge clk) begin
    if (mem_wren) ram[mem_address] <= mem_data;
    if (mem_rden) ram_r1 <= ram[mem_address];
    mem_q <= ram_r1;
  end

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0]  ref_ram [256];
  logic [EW-1:0]  exp_q[$];
  logic [DNW-1:0] exp_done_q[$];
  int busy_lo = 0;   // cycle the accepted rd_start was sampled
  int busy_hi = -1;  // cycle of the expected rd_done
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp_v);
    end
  endtask

  function automatic int exp_count(input logic [AW-1:0] raw);
    return (int'(raw) > PN - 1) ? PN - 1 : int'(raw);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    while (cyc <= busy_hi) idle(1);
  endtask

  // Pulse rd_start for one cycle; if the controller should be idle,
  // predict the whole stream from the shadow RAM.
  task automatic do_read();
    int n;
    int c0;
    rd_start = 1'b1;
    if (cyc > busy_hi) begin
      c0 = cyc;
      n  = exp_count(ref_ram[0][AW-1:0]);
      busy_lo = c0;
      for (int p = 1; p <= n; p++)
        exp_q.push_back({32'(c0 + 5 + p), ref_ram[p], AW'(p), (p == n)});
      busy_hi = (n == 0) ? c0 + 4 : c0 + 5 + n;
      exp_done_q.push_back({32'(busy_hi), AW'(n)});
    end
    @(posedge clk);
    #1;
    rd_start = 1'b0;
  endtask

  // Hold wr_req until granted (bounded), then record the write.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output int gcyc);
    bit got;
    got = 1'b0;
    gcyc = -1;
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    for (int k = 0; k < 600 && !got; k++) begin
      @(negedge clk);
      if (wr_grant) begin
        got  = 1'b1;
        gcyc = cyc;
      end
    end
    chk("write_granted_within_budget", got, 1'b1);
    if (got) ref_ram[a] = d;
    @(posedge clk);
    #1;
    wr_req = 1'b0;
  endtask

  task automatic write_count(input int n);
    logic [DW-1:0] v;
    int g;
    v = {$urandom, $urandom, $urandom};
    v[AW-1:0] = AW'(n);
    do_write('0, v, g);
  endtask

  task automatic write_rand(input logic [AW-1:0] a);
    int g;
    do_write(a, {$urandom, $urandom, $urandom}, g);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd_busy"}, rd_busy, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_pid"}, rd_pid, 0);
    chk({tag, "_rd_last"}, rd_last, 0);
    chk({tag, "_rd_done"}, rd_done, 0);
    chk({tag, "_rd_count"}, rd_count, 0);
    chk({tag, "_wr_grant"}, wr_grant, 0);
    chk({tag, "_mem_address"}, mem_address, 0);
    chk({tag, "_mem_rden"}, mem_rden, 0);
    chk({tag, "_mem_wren"}, mem_wren, 0);
    chk({tag, "_mem_data"}, mem_data, 0);
  endtask

  // ---------------- monitor ----------------
  logic [EW-1:0]  mon_e;
  logic [DNW-1:0] mon_d;
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("mem_port_exclusive", mem_rden & mem_wren, 0);
      chk("rd_busy", rd_busy, (cyc >= busy_lo + 1) && (cyc <= busy_hi));
      chk("wr_grant", wr_grant, wr_req && !((cyc >= busy_lo) && (cyc <= busy_hi)));
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          chk("rd_valid_unexpected", rd_valid, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rd_valid_cycle", cyc, mon_e[EW-1 -: 32]);
          chk("rd_data", rd_data, mon_e[AW+1 +: DW]);
          chk("rd_pid", rd_pid, mon_e[1 +: AW]);
          chk("rd_last", rd_last, mon_e[0]);
        end
      end else begin
        chk("rd_last_without_valid", rd_last, 0);
        if (exp_q.size() > 0 && cyc >= int'(exp_q[0][EW-1 -: 32])) begin
          chk("rd_valid_missing", rd_valid, 1);
          void'(exp_q.pop_front());
        end
      end
      if (rd_done) begin
        if (exp_done_q.size() == 0) begin
          chk("rd_done_unexpected", rd_done, 0);
        end else begin
          mon_d = exp_done_q.pop_front();
          chk("rd_done_cycle", cyc, mon_d[DNW-1 -: 32]);
          chk("rd_count", rd_count, mon_d[AW-1:0]);
        end
      end else if (exp_done_q.size() > 0 && cyc >= int'(exp_done_q[0][DNW-1 -: 32])) begin
        chk("rd_done_missing", rd_done, 1);
        void'(exp_done_q.pop_front());
      end
    end
  end

  // ---------------- global time bound ----------------
  initial begin
    #500000;
    $display("FAIL global_timeout at cycle %0d: got no finish, expected finish", cyc);
    $fatal(1, "time bound expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] v;
    logic [DW-1:0] x;
    int g;
    int exp_g;
    int op;

    for (int i = 0; i < 256; i++) begin
      v = {$urandom, $urandom, $urandom};
      ram[i] <= v;
      ref_ram[i] = v;
    end
    rd_start = 1'b0;
    wr_req   = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rst      = 1'b1;

    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // count = 5, back-to-back writes of the particle words
    for (int a = 1; a <= 5; a++) write_rand(AW'(a));
    write_count(5);
    do_read();
    wait_idle();

    // empty cell
    write_count(0);
    do_read();
    wait_idle();

    // oversize count clamps to PN-1
    write_count(250);
    do_read();
    wait_idle();

    // simultaneous write request and read start: read wins, write waits
    write_count(4);
    x = {$urandom, $urandom, $urandom};
    wr_req  = 1'b1;
    wr_addr = AW'(3);
    wr_data = x;
    do_read();
    exp_g = busy_hi + 1;
    do_write(AW'(3), x, g);
    chk("deferred_write_grant_cycle", g, exp_g);
    wait_idle();
    do_read();
    wait_idle();

    // asynchronous reset in cycle 5 of a 10-particle stream
    write_count(10);
    do_read();
    idle(4);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("midstream_reset");
    exp_q.delete();
    exp_done_q.delete();
    busy_lo = 0;
    busy_hi = -1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_read();
    wait_idle();

    // second rd_start at cycle 3 of a stream is ignored
    write_count(6);
    do_read();
    idle(2);
    do_read();
    wait_idle();

    // randomized mix of reads, writes and gaps
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: write_count(($urandom_range(0, 4) == 0) ? 255 : $urandom_range(0, 12));
        1: write_rand(AW'($urandom_range(1, 15)));
        2: do_read();
        3: idle($urandom_range(1, 6));
        default: begin
          do_read();
          idle($urandom_range(1, 4));
          do_read();
        end
      endcase
    end
    wait_idle();
    idle(5);

    chk("stream_queue_drained", exp_q.size(), 0);
    chk("done_queue_drained", exp_done_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
